simon_round_ctrl: RTL

Round sequencer for the Simon Says game. It generates and stores the pattern, replays it on the four LEDs at the slow-tick rate, and hands control to the player. It then checks the player's button presses entry by entry and either advances the level or ends the game. It drives the LED bank and the player/result flags consumed by the score displays.

---
 rtl/simon_round_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/simon_round_ctrl.sv
// Simon Says round sequencer: pattern generation, LED playback,
// player entry checking and win/lose tracking.
module simon_round_ctrl #(
  parameter int         MAX_LEN       = 32,
  parameter logic [7:0] SEED          = 8'hA5,
  parameter int         ON_TICKS      = 1,
  parameter int         OFF_TICKS     = 1,
  parameter int         TIMEOUT_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] btn_n,
  output logic [3:0] leds,
  output logic       is_player,
  output logic       correct,
  output logic       wrong,
  output logic [5:0] level,
  output logic       game_over
);

  localparam int T01 =
    (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMAX =
    (T01 > TIMEOUT_TICKS) ? T01 : TIMEOUT_TICKS;
  localparam int CW = $clog2(TMAX + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] ON_C  = CW'(ON_TICKS);
  localparam logic [CW-1:0] OFF_C = CW'(OFF_TICKS);
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT_TICKS);
  localparam logic [5:0]    MAX_C = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    RELEASE,
    WIN,
    LOSE
  } state_t;

  state_t        state, state_d;
  logic [7:0]    lfsr, lfsr_d, lfsr_next;
  logic [5:0]    idx, idx_d;
  logic [5:0]    level_d;
  logic [CW-1:0] tick_cnt, tick_d, tick_inc;
  logic [3:0]    btn_prev;
  logic          correct_d, wrong_d, seq_we;

  logic [1:0]    seq [MAX_LEN];
  logic [1:0]    cur_sym;
  logic [3:0]    cur_hot, pressed;
  logic          press, valid, match, last;

  always_comb begin
    lfsr_next = {lfsr[6:0],
                 lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    cur_sym   = seq[idx[AW-1:0]];
    cur_hot   = 4'b0001 << cur_sym;
    pressed   = ~btn_n;
    press     = (btn_prev == 4'hF) && (btn_n != 4'hF);
    valid     = $onehot(pressed);
    match     = valid && (pressed == cur_hot);
    last      = (idx == level - 6'd1);
    tick_inc  = tick_cnt + 1'b1;
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    tick_d    = tick_cnt;
    level_d   = level;
    lfsr_d    = lfsr;
    seq_we    = 1'b0;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    unique case (state)
      IDLE, WIN, LOSE: begin
        if (start) begin
          level_d = 6'd0;
          state_d = GEN;
        end
      end
      GEN: begin
        seq_we  = 1'b1;
        level_d = level + 6'd1;
        lfsr_d  = lfsr_next;
        idx_d   = 6'd0;
        tick_d  = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (tick) begin
          if (tick_inc == ON_C) begin
            tick_d  = '0;
            state_d = SHOW_OFF;
          end else begin
            tick_d = tick_inc;
          end
        end
      end
      SHOW_OFF: begin
        if (tick) begin
          if (tick_inc == OFF_C) begin
            tick_d = '0;
            if (last) begin
              idx_d   = 6'd0;
              state_d = WAIT_IN;
            end else begin
              idx_d   = idx + 6'd1;
              state_d = SHOW_ON;
            end
          end else begin
            tick_d = tick_inc;
          end
        end
      end
      WAIT_IN: begin
        // a press edge wins over a coincident tick
        if (press) begin
          if (match) begin
            state_d = RELEASE;
          end else begin
            wrong_d = 1'b1;
            state_d = LOSE;
          end
        end else if (tick) begin
          if (tick_inc == TO_C) begin
            wrong_d = 1'b1;
            state_d = LOSE;
          end else begin
            tick_d = tick_inc;
          end
        end
      end
      RELEASE: begin
        if (btn_n == 4'hF) begin
          if (last) begin
            correct_d = 1'b1;
            state_d   = (level == MAX_C) ? WIN : GEN;
          end else begin
            idx_d   = idx + 6'd1;
            tick_d  = '0;
            state_d = WAIT_IN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    leds      = 4'h0;
    is_player = 1'b0;
    game_over = 1'b0;
    unique case (state)
      SHOW_ON: leds = cur_hot;
      WAIT_IN: is_player = 1'b1;
      RELEASE: begin
        is_player = 1'b1;
        // feedback follows the registered button sample
        if (btn_prev != 4'hF) leds = cur_hot;
      end
      WIN: begin
        leds      = 4'hF;
        game_over = 1'b1;
      end
      LOSE: game_over = 1'b1;
      default: leds = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= SEED;
      idx      <= 6'd0;
      tick_cnt <= '0;
      btn_prev <= 4'hF;
      level    <= 6'd0;
      correct  <= 1'b0;
      wrong    <= 1'b0;
    end else begin
      state    <= state_d;
      lfsr     <= lfsr_d;
      idx      <= idx_d;
      tick_cnt <= tick_d;
      btn_prev <= btn_n;
      level    <= level_d;
      correct  <= correct_d;
      wrong    <= wrong_d;
    end
  end

  always_ff @(posedge clk) begin
    if (seq_we && !rst)
      seq[level[AW-1:0]] <= lfsr_next[1:0];
  end

endmodule
